// File: rtl/calc1_pkg.sv
// Shared calc1 definitions: port state encoding, opcode and response-code constants,
// and default bus geometry used by the port scheduler.
package calc1_pkg;

    localparam int CALC1_NPORTS = 4;
    localparam int CALC1_DW     = 32;

    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;

    localparam logic [1:0] RSP_NONE = 2'b00;
    localparam logic [1:0] RSP_OK   = 2'b01;
    localparam logic [1:0] RSP_ERR  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        SEND1,
        SEND2,
        WAIT,
        DONE
    } port_state_t;

    // A port that has issued a request and is still waiting on its outcome.
    function automatic logic port_active(input port_state_t s);
        return (s == SEND1) || (s == SEND2) || (s == WAIT);
    endfunction

endpackage

// File: rtl/calc1_port_ctrl.sv
// One calc1 DUV port: two-cycle request sequencing, response/timeout capture and
// a saturating latency counter; holds its completion until released by the drain.
module calc1_port_ctrl
    import calc1_pkg::*;
#(
    parameter int DW      = CALC1_DW,
    parameter int TIMEOUT = 64,
    parameter int LW      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    input  logic [3:0]    i_op,
    input  logic [DW-1:0] i_op1,
    input  logic [DW-1:0] i_op2,
    input  logic [1:0]    i_resp,
    input  logic [DW-1:0] i_resp_data,
    input  logic          i_release,
    output logic          o_idle,
    output logic          o_done,
    output logic [3:0]    o_req_cmd,
    output logic [DW-1:0] o_req_data,
    output logic [1:0]    o_code,
    output logic [DW-1:0] o_data,
    output logic          o_timeout,
    output logic [LW-1:0] o_latency
);

    port_state_t   r_state;
    port_state_t   w_next;
    logic [3:0]    r_op;
    logic [DW-1:0] r_op1;
    logic [DW-1:0] r_op2;
    logic [LW-1:0] r_lat;
    logic [1:0]    r_code;
    logic [DW-1:0] r_data;
    logic          r_timeout;
    logic          w_active;
    logic          w_resp_seen;
    logic          w_expired;
    logic          w_capture;

    assign w_active    = port_active(r_state);
    assign w_resp_seen = (i_resp != RSP_NONE);
    assign w_expired   = (r_state == WAIT) && (r_lat == LW'(TIMEOUT));
    // A response during SEND1/SEND2 is a DUV protocol error but is still captured.
    assign w_capture   = w_active && (w_resp_seen || w_expired);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        o_req_cmd  = '0;
        o_req_data = '0;
        case (r_state)
            IDLE: begin
                if (i_start) w_next = SEND1;
            end
            SEND1: begin
                o_req_cmd  = r_op;
                o_req_data = r_op1;
                w_next     = w_resp_seen ? DONE : SEND2;
            end
            SEND2: begin
                o_req_data = r_op2;
                w_next     = w_resp_seen ? DONE : WAIT;
            end
            WAIT: begin
                if (w_capture) w_next = DONE;
            end
            DONE: begin
                if (i_release) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= '0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_lat     <= '0;
            r_code    <= '0;
            r_data    <= '0;
            r_timeout <= 1'b0;
        end else if (i_start && (r_state == IDLE)) begin
            r_op      <= i_op;
            r_op1     <= i_op1;
            r_op2     <= i_op2;
            r_lat     <= LW'(1);
            r_code    <= RSP_NONE;
            r_data    <= '0;
            r_timeout <= 1'b0;
        end else if (w_capture) begin
            // Counter is frozen here so the reported latency is the response cycle's count.
            r_code    <= i_resp;
            r_data    <= w_resp_seen ? i_resp_data : '0;
            r_timeout <= !w_resp_seen;
        end else if (w_active && (r_lat != '1)) begin
            r_lat <= r_lat + 1'b1;
        end
    end

    assign o_idle    = (r_state == IDLE);
    assign o_done    = (r_state == DONE);
    assign o_code    = r_code;
    assign o_data    = r_data;
    assign o_timeout = r_timeout;
    assign o_latency = r_lat;

endmodule

// File: rtl/calc1_port_scheduler.sv
// Spreads one calc1 command stream over NPORTS DUV ports with round-robin allocation
// and round-robin draining of completions into a single registered response channel.
module calc1_port_scheduler
    import calc1_pkg::*;
#(
    parameter int NPORTS  = CALC1_NPORTS,
    parameter int DW      = CALC1_DW,
    parameter int TIMEOUT = 64,
    parameter int LW      = 16
) (
    input  logic                 c_clk,
    input  logic                 reset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [3:0]           cmd_op,
    input  logic [DW-1:0]        cmd_op1,
    input  logic [DW-1:0]        cmd_op2,
    output logic [4*NPORTS-1:0]  req_cmd_out,
    output logic [DW*NPORTS-1:0] req_data_out,
    input  logic [2*NPORTS-1:0]  out_resp_in,
    input  logic [DW*NPORTS-1:0] out_data_in,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [1:0]           rsp_port,
    output logic [1:0]           rsp_code,
    output logic                 rsp_timeout,
    output logic [DW-1:0]        rsp_data,
    output logic [LW-1:0]        rsp_latency,
    output logic                 busy
);

    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    logic [NPORTS-1:0] w_idle;
    logic [NPORTS-1:0] w_done;
    logic [NPORTS-1:0] w_start;
    logic [NPORTS-1:0] w_release;
    logic [NPORTS-1:0] w_timeout;
    logic [1:0]        w_code [NPORTS];
    logic [DW-1:0]     w_data [NPORTS];
    logic [LW-1:0]     w_lat  [NPORTS];

    logic [PW-1:0]     r_issue_ptr;
    logic [PW-1:0]     r_drain_ptr;
    logic [PW-1:0]     r_rsp_idx;
    logic              r_rsp_valid;
    logic              r_rsp_timeout;
    logic [1:0]        r_rsp_code;
    logic [DW-1:0]     r_rsp_data;
    logic [LW-1:0]     r_rsp_lat;

    logic              w_accept;
    logic              w_rsp_hs;
    logic              w_alloc_found;
    logic [PW-1:0]     w_alloc_idx;
    logic              w_drain_found;
    logic [PW-1:0]     w_drain_idx;
    logic [PW-1:0]     w_drain_base;
    logic [NPORTS-1:0] w_drain_cand;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] idx);
        return (idx == PW'(NPORTS - 1)) ? '0 : idx + 1'b1;
    endfunction

    assign cmd_ready = reset_n & (|w_idle);
    assign w_accept  = cmd_valid & cmd_ready;
    assign busy      = ~(&w_idle);
    assign w_rsp_hs  = r_rsp_valid & rsp_ready;

    always_comb begin
        w_alloc_found = 1'b0;
        w_alloc_idx   = '0;
        for (int unsigned k = 0; k < NPORTS; k++) begin
            if (!w_alloc_found && w_idle[PW'((32'(r_issue_ptr) + k) % NPORTS)]) begin
                w_alloc_found = 1'b1;
                w_alloc_idx   = PW'((32'(r_issue_ptr) + k) % NPORTS);
            end
        end
    end

    // On a handshake the next completion is chosen in the same edge, skipping the port being freed.
    always_comb begin
        w_drain_base  = w_rsp_hs ? wrap_inc(r_rsp_idx) : r_drain_ptr;
        w_drain_cand  = w_done & ~(w_rsp_hs ? (NPORTS'(1) << r_rsp_idx) : '0);
        w_drain_found = 1'b0;
        w_drain_idx   = '0;
        for (int unsigned k = 0; k < NPORTS; k++) begin
            if (!w_drain_found && w_drain_cand[PW'((32'(w_drain_base) + k) % NPORTS)]) begin
                w_drain_found = 1'b1;
                w_drain_idx   = PW'((32'(w_drain_base) + k) % NPORTS);
            end
        end
    end

    for (genvar g = 0; g < NPORTS; g++) begin : g_port
        assign w_start[g]   = w_accept && (w_alloc_idx == PW'(g));
        assign w_release[g] = w_rsp_hs && (r_rsp_idx == PW'(g));

        calc1_port_ctrl #(
            .DW      (DW),
            .TIMEOUT (TIMEOUT),
            .LW      (LW)
        ) u_port (
            .clk         (c_clk),
            .rst_n       (reset_n),
            .i_start     (w_start[g]),
            .i_op        (cmd_op),
            .i_op1       (cmd_op1),
            .i_op2       (cmd_op2),
            .i_resp      (out_resp_in[2*g +: 2]),
            .i_resp_data (out_data_in[DW*g +: DW]),
            .i_release   (w_release[g]),
            .o_idle      (w_idle[g]),
            .o_done      (w_done[g]),
            .o_req_cmd   (req_cmd_out[4*g +: 4]),
            .o_req_data  (req_data_out[DW*g +: DW]),
            .o_code      (w_code[g]),
            .o_data      (w_data[g]),
            .o_timeout   (w_timeout[g]),
            .o_latency   (w_lat[g])
        );
    end

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_issue_ptr   <= '0;
            r_drain_ptr   <= '0;
            r_rsp_idx     <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_code    <= '0;
            r_rsp_data    <= '0;
            r_rsp_lat     <= '0;
        end else begin
            if (w_accept) r_issue_ptr <= wrap_inc(w_alloc_idx);
            if (w_rsp_hs) r_drain_ptr <= wrap_inc(r_rsp_idx);
            if (!r_rsp_valid || w_rsp_hs) begin
                r_rsp_valid <= w_drain_found;
                if (w_drain_found) begin
                    r_rsp_idx     <= w_drain_idx;
                    r_rsp_code    <= w_code[w_drain_idx];
                    r_rsp_data    <= w_data[w_drain_idx];
                    r_rsp_timeout <= w_timeout[w_drain_idx];
                    r_rsp_lat     <= w_lat[w_drain_idx];
                end
            end
        end
    end

    assign rsp_valid   = r_rsp_valid;
    assign rsp_port    = 2'(r_rsp_idx);
    assign rsp_code    = r_rsp_code;
    assign rsp_timeout = r_rsp_timeout;
    assign rsp_data    = r_rsp_data;
    assign rsp_latency = r_rsp_lat;

endmodule
